// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding, requester IDs,
// default timing/size parameters and the word-access legality check.
package dmem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int DEF_READ_LATENCY = 2;
    localparam int DEF_MEM_BYTES    = 1024;

    // A word access is rejected when misaligned or when its last byte falls past the memory end.
    function automatic logic addr_illegal(input logic [31:0] addr, input logic [31:0] last_word);
        return (addr[1:0] != 2'b00) || (addr > last_word);
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant: one-hot grant from two requests, pointer moves to the
// non-granted port whenever a grant is taken.
module rr_grant2
    import dmem_arb_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = (r_ptr == PORT_DMA) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_ptr <= PORT_CPU;
        end else if (i_advance && (o_grant != 2'b00)) begin
            r_ptr <= ~o_grant[1];
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store stage (port 0)
// and the loader/DMA engine (port 1); one word transaction in flight at a time.
module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int MEM_BYTES    = DEF_MEM_BYTES
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        Write0,
    input  logic        Write1,
    input  logic [31:0] Addr0,
    input  logic [31:0] Addr1,
    input  logic [31:0] WData0,
    input  logic [31:0] WData1,
    output logic        Ack0,
    output logic        Ack1,
    output logic        Err,
    output logic [31:0] RData,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEnable,
    output logic        MemRead,
    input  logic [31:0] MemData
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [3:0]  LAT_LOAD  = 4'(READ_LATENCY - 1);

    logic [1:0]  r_state;
    logic        r_port;
    logic        r_write;
    logic        r_err;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic [1:0]  w_grant;
    logic        w_idle;
    logic        w_take;
    logic        w_gport;
    logic        w_gwrite;
    logic [31:0] w_gaddr;
    logic [31:0] w_gwdata;
    logic        w_bad;

    assign w_idle = (r_state == ST_IDLE);
    assign w_take = w_idle && (w_grant != 2'b00);

    rr_grant2 u_rr (
        .CLK       (CLK),
        .Reset     (Reset),
        .i_req     ({Req1, Req0}),
        .i_advance (w_idle),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_gport  = w_grant[1];
        w_gwrite = Write0;
        w_gaddr  = Addr0;
        w_gwdata = WData0;
        if (w_gport == PORT_DMA) begin
            w_gwrite = Write1;
            w_gaddr  = Addr1;
            w_gwdata = WData1;
        end
        w_bad = addr_illegal(w_gaddr, LAST_WORD);
    end

    // Rejected requests skip ACCESS entirely so the memory pins never move for them.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_port      <= PORT_CPU;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= 4'd0;
            r_rdata     <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_port  <= w_gport;
                        r_write <= w_gwrite;
                        r_err   <= w_bad;
                        r_cnt   <= LAT_LOAD;
                        if (w_bad) begin
                            r_state <= ST_DONE;
                            r_rdata <= 32'd0;
                        end else begin
                            r_state     <= ST_ACCESS;
                            r_mem_addr  <= w_gaddr;
                            r_mem_wdata <= w_gwdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_write) begin
                        r_state <= ST_DONE;
                    end else if (r_cnt == 4'd0) begin
                        r_rdata <= MemData;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Ack0           = (r_state == ST_DONE) && (r_port == PORT_CPU);
    assign Ack1           = (r_state == ST_DONE) && (r_port == PORT_DMA);
    assign Err            = (r_state == ST_DONE) && r_err;
    assign MemWriteEnable = (r_state == ST_ACCESS) && r_write;
    assign MemRead        = (r_state == ST_ACCESS) && !r_write;
    assign RData          = r_rdata;
    assign MemAddress     = r_mem_addr;
    assign MemWriteData   = r_mem_wdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: directed transactions push expectations,
// a negedge monitor pops and compares on every Ack.
module tb_data_memory_arbiter;

    localparam int RL = 2;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Req0 = 1'b0, Req1 = 1'b0, Write0 = 1'b0, Write1 = 1'b0;
    logic [31:0] Addr0 = '0, Addr1 = '0, WData0 = '0, WData1 = '0;
    logic        Ack0, Ack1, Err, MemWriteEnable, MemRead;
    logic [31:0] RData, MemAddress, MemWriteData, MemData;

    logic        x_req = 1'b0;
    logic [31:0] x_addr = '0;
    logic        a1_ack0, a1_ack1, a1_err, a1_we, a1_rd;
    logic [31:0] a1_rdata, a1_maddr, a1_mwdata, a1_mdata;
    logic        a4_ack0, a4_ack1, a4_err, a4_we, a4_rd;
    logic [31:0] a4_rdata, a4_maddr, a4_mwdata, a4_mdata;

    typedef struct {
        logic        port;
        logic        wr;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          sample;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] model_rdata = 32'd0;
    logic [31:0] mem [0:255];
    logic        mem_init = 1'b0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem_init <= 1'b1;
        end else if (MemWriteEnable) begin
            mem[MemAddress[9:2]] <= MemWriteData;
        end
    end

    assign MemData  = MemRead ? mem[MemAddress[9:2]] : 32'hBAD0_BAD0;
    assign a1_mdata = a1_rd ? (a1_maddr ^ 32'h5A5A_0000) : 32'hBAD0_BAD0;
    assign a4_mdata = a4_rd ? (a4_maddr ^ 32'h5A5A_0000) : 32'hBAD0_BAD0;

    data_memory_arbiter #(.READ_LATENCY(RL), .MEM_BYTES(1024)) dut (
        .CLK(CLK), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Write0(Write0), .Write1(Write1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Ack0(Ack0), .Ack1(Ack1), .Err(Err), .RData(RData), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemWriteEnable(MemWriteEnable), .MemRead(MemRead),
        .MemData(MemData)
    );

    data_memory_arbiter #(.READ_LATENCY(1), .MEM_BYTES(1024)) dut_rl1 (
        .CLK(CLK), .Reset(Reset), .Req0(1'b0), .Req1(x_req), .Write0(1'b0), .Write1(1'b0),
        .Addr0(32'd0), .Addr1(x_addr), .WData0(32'd0), .WData1(32'd0),
        .Ack0(a1_ack0), .Ack1(a1_ack1), .Err(a1_err), .RData(a1_rdata), .MemAddress(a1_maddr),
        .MemWriteData(a1_mwdata), .MemWriteEnable(a1_we), .MemRead(a1_rd), .MemData(a1_mdata)
    );

    data_memory_arbiter #(.READ_LATENCY(4), .MEM_BYTES(1024)) dut_rl4 (
        .CLK(CLK), .Reset(Reset), .Req0(1'b0), .Req1(x_req), .Write0(1'b0), .Write1(1'b0),
        .Addr0(32'd0), .Addr1(x_addr), .WData0(32'd0), .WData1(32'd0),
        .Ack0(a4_ack0), .Ack1(a4_ack1), .Err(a4_err), .RData(a4_rdata), .MemAddress(a4_maddr),
        .MemWriteData(a4_mwdata), .MemWriteEnable(a4_we), .MemRead(a4_rd), .MemData(a4_mdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ack(input logic port);
        int t;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!(port ? Ack1 : Ack0) && t < 40);
        if (!(port ? Ack1 : Ack0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_timeout: port %0d saw no Ack in %0d cycles", port, t);
        end
    endtask

    task automatic push_exp(input logic port, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd_val,
                            input logic bad, input int sample);
        exp_t e;
        if (bad) model_rdata = 32'd0;
        else if (!wr) model_rdata = rd_val;
        e.port = port; e.wr = wr; e.err = bad; e.addr = addr; e.wdata = wdata;
        e.rdata = model_rdata; e.sample = sample;
        sbq.push_back(e);
    endtask

    task automatic txn(input logic port, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd_val,
                       input logic bad, input logic sync);
        if (sync) @(negedge CLK);
        push_exp(port, wr, addr, wdata, rd_val, bad, cyc + 1);
        if (port) begin
            Write1 = wr; Addr1 = addr; WData1 = wdata; Req1 = 1'b1;
        end else begin
            Write0 = wr; Addr0 = addr; WData0 = wdata; Req0 = 1'b1;
        end
        wait_ack(port);
        if (port) Req1 = 1'b0;
        else Req0 = 1'b0;
    endtask

    // Monitor: mutual exclusion every active cycle, pin checks during ACCESS, full compare on Ack.
    initial begin
        int   rd_cnt;
        int   we_cnt;
        int   lat;
        exp_t e;
        rd_cnt = 0;
        we_cnt = 0;
        forever begin
            @(negedge CLK);
            if (MemWriteEnable || MemRead || Ack0 || Ack1) begin
                check("we_rd_exclusive", {31'b0, MemWriteEnable & MemRead}, 32'd0);
                check("ack_exclusive", {31'b0, Ack0 & Ack1}, 32'd0);
            end
            if (Reset) begin
                rd_cnt = 0;
                we_cnt = 0;
            end else begin
                if (MemRead) rd_cnt++;
                if (MemWriteEnable) we_cnt++;
                if ((MemRead || MemWriteEnable) && sbq.size() > 0) begin
                    check("mem_address", MemAddress, sbq[0].addr);
                    if (MemWriteEnable) check("mem_wdata", MemWriteData, sbq[0].wdata);
                end
                if (Ack0 || Ack1) begin
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_ack: Ack0=%0b Ack1=%0b, expected none", Ack0, Ack1);
                    end else begin
                        e = sbq.pop_front();
                        check("ack_port", {31'b0, Ack1}, {31'b0, e.port});
                        check("err", {31'b0, Err}, {31'b0, e.err});
                        check("rdata", RData, e.rdata);
                        if (e.sample >= 0) begin
                            lat = e.err ? 0 : (e.wr ? 1 : RL);
                            check("ack_latency", 32'(cyc - e.sample), 32'(lat));
                        end
                        check("memread_cycles", 32'(rd_cnt), (!e.err && !e.wr) ? 32'(RL) : 32'd0);
                        check("memwrite_cycles", 32'(we_cnt), (!e.err && e.wr) ? 32'd1 : 32'd0);
                    end
                    rd_cnt = 0;
                    we_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s;
        int  c1, c4;
        logic d1, d4;

        // Reset held with a pending port 0 read: nothing may move.
        Req0 = 1'b1; Write0 = 1'b0; Addr0 = 32'h20;
        repeat (3) begin
            @(negedge CLK);
            check("rst_ack0", {31'b0, Ack0}, 32'd0);
            check("rst_memread", {31'b0, MemRead}, 32'd0);
            check("rst_memwe", {31'b0, MemWriteEnable}, 32'd0);
            check("rst_memaddr", MemAddress, 32'd0);
            check("rst_rdata", RData, 32'd0);
        end
        Reset = 1'b0;
        txn(1'b0, 1'b0, 32'h20, 32'd0, 32'h1000_0008, 1'b0, 1'b0);

        txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        txn(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        txn(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b1);
        txn(1'b1, 1'b0, 32'h40, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b1);
        txn(1'b0, 1'b1, 32'h44, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
        @(negedge CLK);
        check("idle_memaddr_hold", MemAddress, 32'h44);

        txn(1'b1, 1'b0, 32'h12, 32'd0, 32'd0, 1'b1, 1'b1);
        txn(1'b1, 1'b0, 32'h3FD, 32'd0, 32'd0, 1'b1, 1'b1);
        txn(1'b1, 1'b1, 32'h400, 32'h0BAD_0BAD, 32'd0, 1'b1, 1'b1);
        @(negedge CLK);
        check("err_memaddr_hold", MemAddress, 32'h44);
        txn(1'b1, 1'b0, 32'h3FC, 32'd0, 32'h1000_00FF, 1'b0, 1'b1);

        // Both ports held back-to-back: grants must alternate 0,1,0,1.
        @(negedge CLK);
        push_exp(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, -1);
        push_exp(1'b1, 1'b0, 32'h40, 32'd0, 32'hCAFE_F00D, 1'b0, -1);
        push_exp(1'b0, 1'b0, 32'h44, 32'd0, 32'h1234_5678, 1'b0, -1);
        push_exp(1'b1, 1'b0, 32'h20, 32'd0, 32'h1000_0008, 1'b0, -1);
        fork
            begin
                Write0 = 1'b0; Addr0 = 32'h10; Req0 = 1'b1;
                wait_ack(1'b0);
                @(negedge CLK);
                Addr0 = 32'h44;
                wait_ack(1'b0);
                Req0 = 1'b0;
            end
            begin
                Write1 = 1'b0; Addr1 = 32'h40; Req1 = 1'b1;
                wait_ack(1'b1);
                @(negedge CLK);
                Addr1 = 32'h20;
                wait_ack(1'b1);
                Req1 = 1'b0;
            end
        join

        // Reset landing in the first ACCESS cycle of a read aborts it.
        @(negedge CLK);
        Write0 = 1'b0; Addr0 = 32'h10; Req0 = 1'b1;
        @(negedge CLK);
        check("abort_in_access", {31'b0, MemRead}, 32'd1);
        Reset = 1'b1; Req0 = 1'b0;
        @(negedge CLK);
        check("abort_memread", {31'b0, MemRead}, 32'd0);
        check("abort_memwe", {31'b0, MemWriteEnable}, 32'd0);
        check("abort_ack0", {31'b0, Ack0}, 32'd0);
        check("abort_memaddr", MemAddress, 32'd0);
        check("abort_rdata", RData, 32'd0);
        @(negedge CLK);
        check("abort_ack0_late", {31'b0, Ack0}, 32'd0);
        Reset = 1'b0;
        model_rdata = 32'd0;
        txn(1'b0, 1'b0, 32'h44, 32'd0, 32'h1234_5678, 1'b0, 1'b1);

        // READ_LATENCY 1 and 4 builds on the same request.
        @(negedge CLK);
        x_addr = 32'h80; x_req = 1'b1;
        s = cyc + 1;
        c1 = 0; c4 = 0; d1 = 1'b0; d4 = 1'b0;
        for (int t = 0; t < 20 && !(d1 && d4); t++) begin
            @(negedge CLK);
            if (!d1) begin
                if (a1_rd) c1++;
                if (a1_ack1) begin
                    d1 = 1'b1;
                    check("rl1_latency", 32'(cyc - s), 32'd1);
                    check("rl1_memread_cycles", 32'(c1), 32'd1);
                    check("rl1_rdata", a1_rdata, 32'h5A5A_0080);
                end
            end
            if (!d4) begin
                if (a4_rd) c4++;
                if (a4_ack1) begin
                    d4 = 1'b1;
                    check("rl4_latency", 32'(cyc - s), 32'd4);
                    check("rl4_memread_cycles", 32'(c4), 32'd4);
                    check("rl4_rdata", a4_rdata, 32'h5A5A_0080);
                end
            end
        end
        x_req = 1'b0;
        if (!(d1 && d4)) begin
            n_vec++;
            n_bad++;
            $display("FAIL rl_ack_timeout: rl1 done=%0b rl4 done=%0b", d1, d4);
        end

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
